// File: rtl/buffer_packet_writer.sv
`default_nettype none
// ============================================================================
// buffer_packet_writer: two-channel round-robin packet writer that brackets
// each packet with write-index push/pop so rejected packets roll back whole.
// Revision: 1.0
// ============================================================================
module buffer_packet_writer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 256,
  parameter int MAX_PKT_LEN = 64,
  parameter int MIN_FREE    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ch0_req,
  input  logic                  i_ch0_valid,
  input  logic [DATA_WIDTH-1:0] i_ch0_data,
  input  logic                  i_ch0_last,
  input  logic                  i_ch0_abort,
  output logic                  o_ch0_grant,
  output logic                  o_ch0_done,
  output logic                  o_ch0_drop,
  input  logic                  i_ch1_req,
  input  logic                  i_ch1_valid,
  input  logic [DATA_WIDTH-1:0] i_ch1_data,
  input  logic                  i_ch1_last,
  input  logic                  i_ch1_abort,
  output logic                  o_ch1_grant,
  output logic                  o_ch1_done,
  output logic                  o_ch1_drop,
  input  logic [15:0]           i_buf_data_size,
  input  logic                  i_buf_stack_overrun,
  output logic                  o_buf_push_write_index,
  output logic                  o_buf_pop_write_index,
  output logic                  o_buf_write_en,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  output logic                  o_busy,
  output logic [15:0]           o_drop_count,
  output logic                  o_fault
);

  localparam logic [15:0] c_usable   = 16'(BUFFER_SIZE - 1);
  localparam logic [15:0] c_max_len  = 16'(MAX_PKT_LEN);
  localparam logic [15:0] c_min_free = 16'(MIN_FREE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    COMMIT   = 2'd2,
    ROLLBACK = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic [15:0]           avail_q, avail_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            drop_q, drop_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [1:0]            w_req;
  logic                  w_cand;
  logic [1:0]            w_owner_oh;
  logic                  w_valid, w_last, w_abort, w_rollback;
  logic [DATA_WIDTH-1:0] w_data;
  logic [15:0]           w_free;

  assign w_req      = {i_ch1_req, i_ch0_req};
  // With both requesting, the channel holding priority wins.
  assign w_cand     = (w_req == 2'b11) ? prio_q : w_req[1];
  assign w_owner_oh = owner_q ? 2'b10 : 2'b01;
  assign w_valid    = owner_q ? i_ch1_valid : i_ch0_valid;
  assign w_last     = owner_q ? i_ch1_last  : i_ch0_last;
  assign w_abort    = owner_q ? i_ch1_abort : i_ch0_abort;
  assign w_data     = owner_q ? i_ch1_data  : i_ch0_data;
  assign w_free     = (i_buf_data_size >= c_usable) ? 16'd0 : (c_usable - i_buf_data_size);
  assign w_rollback = w_abort || (w_valid && (cnt_q == avail_q));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    avail_d    = avail_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    drop_d     = 2'b00;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    we_d       = 1'b0;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    fault_d    = fault_q | i_buf_stack_overrun;

    unique case (state_q)
      IDLE: begin
        if ((w_req != 2'b00) && (w_free >= c_min_free)) begin
          owner_d = w_cand;
          avail_d = (w_free < c_max_len) ? w_free : c_max_len;
          cnt_d   = 16'd0;
          push_d  = 1'b1;
          grant_d = w_cand ? 2'b10 : 2'b01;
          state_d = XFER;
        end
      end
      XFER: begin
        if (w_rollback) begin
          pop_d   = 1'b1;
          drop_d  = w_owner_oh;
          state_d = ROLLBACK;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else if (w_valid) begin
          we_d   = 1'b1;
          data_d = w_data;
          cnt_d  = cnt_q + 16'd1;
          if (w_last) begin
            done_d  = w_owner_oh;
            state_d = COMMIT;
          end
        end
      end
      COMMIT, ROLLBACK: begin
        grant_d = 2'b00;
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      avail_q    <= 16'd0;
      cnt_q      <= 16'd0;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      drop_q     <= 2'b00;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      data_q     <= '0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      avail_q    <= avail_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_ch0_grant            = grant_q[0];
  assign o_ch1_grant            = grant_q[1];
  assign o_ch0_done             = done_q[0];
  assign o_ch1_done             = done_q[1];
  assign o_ch0_drop             = drop_q[0];
  assign o_ch1_drop             = drop_q[1];
  assign o_buf_push_write_index = push_q;
  assign o_buf_pop_write_index  = pop_q;
  assign o_buf_write_en         = we_q;
  assign o_buf_data             = data_q;
  assign o_busy                 = busy_q;
  assign o_drop_count           = drop_cnt_q;
  assign o_fault                = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_buffer_packet_writer.sv
`default_nettype none
// Self-checking bench for buffer_packet_writer: packet-level reference model
// plus a simple byte-buffer occupancy model on the write side.
`timescale 1ns/1ps
module tb_buffer_packet_writer;
  localparam int BS  = 256;
  localparam int MPL = 64;
  localparam int MF  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0, valid = '0, last = '0, abort = '0;
  logic [1:0][7:0] dat = '0;
  logic overrun = 1'b0;
  logic [15:0] size;
  logic [1:0] grant, done, drop;
  logic push, pop, we, busy, fault;
  logic [7:0] bdata;
  logic [15:0] dcount;

  int occ = 0, occ_saved = 0;
  assign size = 16'(occ);

  always #5 clk = ~clk;

  buffer_packet_writer #(.DATA_WIDTH(8), .BUFFER_SIZE(BS), .MAX_PKT_LEN(MPL), .MIN_FREE(MF)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch0_req(req[0]), .i_ch0_valid(valid[0]), .i_ch0_data(dat[0]), .i_ch0_last(last[0]),
    .i_ch0_abort(abort[0]), .o_ch0_grant(grant[0]), .o_ch0_done(done[0]), .o_ch0_drop(drop[0]),
    .i_ch1_req(req[1]), .i_ch1_valid(valid[1]), .i_ch1_data(dat[1]), .i_ch1_last(last[1]),
    .i_ch1_abort(abort[1]), .o_ch1_grant(grant[1]), .o_ch1_done(done[1]), .o_ch1_drop(drop[1]),
    .i_buf_data_size(size), .i_buf_stack_overrun(overrun),
    .o_buf_push_write_index(push), .o_buf_pop_write_index(pop), .o_buf_write_en(we),
    .o_buf_data(bdata), .o_busy(busy), .o_drop_count(dcount), .o_fault(fault)
  );

  // Reference model: packet ownership, byte budget and pending end-of-packet.
  int m_owner = -1, m_prio = 0, m_avail = 0, m_cnt = 0, m_dc = 0;
  bit m_end = 0, m_fault = 0;
  logic [1:0] e_grant = '0, e_done = '0, e_drop = '0;
  logic e_push = 0, e_pop = 0, e_we = 0, e_busy = 0;
  logic [7:0] e_data = '0;

  int checks = 0, errors = 0;
  int n_we = 0, n_done = 0, n_drop = 0, n_pop = 0, push_bad = 0;
  logic [1:0] prev_grant = '0;
  int order[$];
  int wbytes[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by the rising edge that just happened, using the inputs it sampled.
  task automatic model_step();
    int free, c;
    e_done = 0; e_drop = 0; e_push = 0; e_pop = 0; e_we = 0;
    if (rst) begin
      m_owner = -1; m_end = 0; m_prio = 0; m_dc = 0; m_fault = 0;
      e_grant = 0; e_busy = 0; e_data = 0;
    end else begin
      if (overrun) m_fault = 1;
      if (m_end) begin
        m_prio = 1 - m_owner; m_owner = -1; m_end = 0; e_grant = 0; e_busy = 0;
      end else if (m_owner < 0) begin
        free = BS - 1 - int'(size);
        if (free < 0) free = 0;
        c = (req == 2'b11) ? m_prio : (req[1] ? 1 : 0);
        if (req != 2'b00 && free >= MF) begin
          m_owner = c; m_avail = (free < MPL) ? free : MPL; m_cnt = 0;
          e_push = 1; e_grant = '0; e_grant[c] = 1'b1; e_busy = 1;
        end
      end else if (abort[m_owner] || (valid[m_owner] && m_cnt == m_avail)) begin
        e_pop = 1; e_drop[m_owner] = 1'b1; m_end = 1;
        if (m_dc < 65535) m_dc++;
      end else if (valid[m_owner]) begin
        e_we = 1; e_data = dat[m_owner]; m_cnt++;
        if (last[m_owner]) begin
          e_done[m_owner] = 1'b1; m_end = 1;
        end
      end
    end
  endtask

  // One cycle: model update, output comparison, monitors, then the buffer reacts to its controls.
  task automatic tick();
    @(negedge clk);
    model_step();
    check("outputs", {grant, done, drop, push, pop, we, busy, fault, dcount},
          {e_grant, e_done, e_drop, e_push, e_pop, e_we, e_busy, m_fault, 16'(m_dc)});
    if (e_we) check("buf_data", bdata, e_data);
    if (grant != 0 && prev_grant == 0) order.push_back(grant[1] ? 1 : 0);
    if (push && prev_grant != 0) push_bad++;
    prev_grant = grant;
    if (we) begin n_we++; wbytes.push_back(int'(bdata)); end
    if (done != 0) n_done++;
    if (drop != 0) n_drop++;
    if (pop) n_pop++;
    if (rst) occ = 0;
    else begin
      if (push) occ_saved = occ;
      if (pop) occ = occ_saved;
      if (we) occ++;
    end
  endtask

  task automatic run_pkt(input int ch_in, input int n, input int base, input bit with_last,
                         input bit do_abort, input bit keep_req);
    int ch, w;
    ch = ch_in;
    if (ch >= 0) req[ch] = 1'b1;
    w = 0;
    while (((ch >= 0) ? !grant[ch] : (grant == 2'b00)) && w < 200) begin tick(); w++; end
    if (w >= 200) begin check("grant_wait", 0, 1); req = '0; return; end
    if (ch < 0) ch = grant[1] ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      valid[ch] = 1'b1; dat[ch] = 8'(base + i); last[ch] = with_last && (i == n - 1);
      tick();
    end
    valid[ch] = 1'b0; last[ch] = 1'b0;
    if (do_abort) begin abort[ch] = 1'b1; tick(); abort[ch] = 1'b0; end
    if (!keep_req) req[ch] = 1'b0;
    w = 0;
    while (grant[ch] && w < 20) begin tick(); w++; end
    if (w >= 20) check("grant_release", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; valid = '0; last = '0; abort = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int we0, dn0, dp0, pp0, occ0, w;
    do_reset();

    // Single 4-byte packet on ch0.
    wbytes.delete(); we0 = n_we; dn0 = n_done;
    run_pkt(0, 4, 8'h11, 1'b1, 1'b0, 1'b0);
    check("t1_writes", n_we - we0, 4);
    check("t1_done", n_done - dn0, 1);
    check("t1_occ", occ, 4);
    for (int i = 0; i < 4; i++) check("t1_byte", (wbytes.size() > i) ? wbytes[i] : -1, 8'h11 + i);
    check("t1_grant_low", grant, 0);

    // Both channels requesting: strict alternation from channel 0.
    do_reset(); occ = 0;
    order.delete(); push_bad = 0;
    req = 2'b11;
    for (int p = 0; p < 3; p++) run_pkt(-1, 2, 8'h40 + 8 * p, 1'b1, 1'b0, 1'b1);
    req = '0;
    check("t2_npkts", order.size(), 3);
    check("t2_order0", (order.size() > 0) ? order[0] : -1, 0);
    check("t2_order1", (order.size() > 1) ? order[1] : -1, 1);
    check("t2_order2", (order.size() > 2) ? order[2] : -1, 0);
    check("t2_push_while_grant", push_bad, 0);
    check("t2_occ", occ, 6);

    // ch1 sends 3 bytes then aborts.
    occ0 = occ; we0 = n_we; dp0 = n_drop; pp0 = n_pop;
    run_pkt(1, 3, 8'h70, 1'b0, 1'b1, 1'b0);
    check("t3_writes", n_we - we0, 3);
    check("t3_drop", n_drop - dp0, 1);
    check("t3_pop", n_pop - pp0, 1);
    check("t3_occ", occ, occ0);
    check("t3_drop_count", dcount, 1);

    // Over-length: the 65th byte forces rollback.
    occ0 = occ; we0 = n_we; dp0 = n_drop;
    run_pkt(0, 65, 0, 1'b0, 1'b0, 1'b0);
    check("t4_writes", n_we - we0, 64);
    check("t4_drop", n_drop - dp0, 1);
    check("t4_occ", occ, occ0);
    check("t4_drop_count", dcount, 2);

    // Nearly full buffer: no grant until drained to 239, then overflow at 16 bytes.
    do_reset();
    occ = 250; req[0] = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (grant != 0) w++; end
    check("t5_no_grant", w, 0);
    while (occ > 239) begin occ--; tick(); end
    we0 = n_we; dp0 = n_drop;
    run_pkt(0, 17, 8'hC0, 1'b0, 1'b0, 1'b0);
    check("t5_writes", n_we - we0, 16);
    check("t5_drop", n_drop - dp0, 1);
    check("t5_occ", occ, 239);
    check("t5_drop_count", dcount, 1);

    // Reset in the middle of a packet.
    req[0] = 1'b1;
    w = 0;
    while (!grant[0] && w < 50) begin tick(); w++; end
    check("t6_grant", grant[0], 1);
    valid[0] = 1'b1; dat[0] = 8'hA0; tick();
    dat[0] = 8'hA1; tick();
    rst = 1'b1; req = '0; valid = '0;
    tick();
    check("t6_reset_outputs", {grant, done, drop, push, pop, we, busy, fault, dcount, bdata}, 0);
    rst = 1'b0;
    tick();

    // Sticky fault.
    overrun = 1'b1; tick(); overrun = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_fault_sticky", fault, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_fault_cleared", fault, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
